// File: rtl/test_status_collector_if.sv
// Severity event stream from the test body's report and assert sites.
// A transfer occurs on a cycle where evt_valid and evt_ready are both high.
interface test_status_collector_if #(
    parameter int ID_WIDTH = 8
);
    logic                evt_valid;
    logic                evt_ready;
    logic [1:0]          evt_sev;
    logic [ID_WIDTH-1:0] evt_id;

    modport master (
        output evt_valid,
        output evt_sev,
        output evt_id,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_sev,
        input  evt_id,
        output evt_ready
    );
endinterface

// File: rtl/test_status_collector.sv
// Counts test severity events, decides when the test ends and its verdict,
// and runs a cycle watchdog so that a hung test still finishes (as a fail).
module test_status_collector #(
    parameter int CNT_WIDTH    = 16,
    parameter int ID_WIDTH     = 8,
    parameter int TIMEOUT      = 1000,
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_ERRORS   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    test_status_collector_if.slave evt,
    input  logic                 i_done,
    output logic [CNT_WIDTH-1:0] o_info_cnt,
    output logic [CNT_WIDTH-1:0] o_warn_cnt,
    output logic [CNT_WIDTH-1:0] o_err_cnt,
    output logic                 o_fatal,
    output logic                 o_first_err_valid,
    output logic [ID_WIDTH-1:0]  o_first_err_id,
    output logic                 o_timeout,
    output logic                 o_busy,
    output logic                 o_finish,
    output logic                 o_pass
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [31:0] WD_LAST =
        (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);
    localparam logic [31:0] DR_LAST = 32'(DRAIN_CYCLES - 1);
    localparam logic [31:0] ERR_MAX = 32'(MAX_ERRORS);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t state, state_nxt;

    logic [31:0]          wd_cnt;
    logic [31:0]          dr_cnt;
    logic [CNT_WIDTH-1:0] err_nxt;
    logic clear, accept, is_err, is_fatal, is_bad;
    logic wd_hit, err_hit, trig, dr_last;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] c
    );
        return (&c) ? c : c + ONE;
    endfunction

    assign evt.evt_ready = (state == RUN) || (state == DRAIN);
    assign accept   = evt.evt_valid && evt.evt_ready;
    assign is_err   = (evt.evt_sev == 2'd2);
    assign is_fatal = (evt.evt_sev == 2'd3);
    assign is_bad   = evt.evt_sev[1];
    assign clear    = i_start && ((state == IDLE) || (state == DONE));

    // Trigger sees this cycle's accepted error, not just the registered count.
    assign err_nxt = (accept && is_err) ? sat_inc(o_err_cnt) : o_err_cnt;
    assign err_hit = (MAX_ERRORS != 0) && (32'(err_nxt) >= ERR_MAX);
    assign wd_hit  = (TIMEOUT != 0) && (wd_cnt == WD_LAST);
    assign trig    = i_done || (accept && is_fatal) || err_hit || wd_hit;
    assign dr_last = (dr_cnt == DR_LAST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (i_start) state_nxt = RUN;
            RUN:     if (trig)    state_nxt = DRAIN;
            DRAIN:   if (dr_last) state_nxt = DONE;
            DONE:    if (i_start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            o_busy   <= 1'b0;
            o_finish <= 1'b0;
        end else begin
            state    <= state_nxt;
            o_busy   <= (state_nxt == RUN) || (state_nxt == DRAIN);
            o_finish <= (state == DRAIN) && dr_last;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wd_cnt    <= '0;
            dr_cnt    <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (clear)
                wd_cnt <= '0;
            else if (state == RUN)
                wd_cnt <= wd_cnt + 32'd1;
            dr_cnt <= (state == DRAIN) ? dr_cnt + 32'd1 : 32'd0;
            if (clear)
                o_timeout <= 1'b0;
            else if ((state == RUN) && wd_hit)
                o_timeout <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_info_cnt        <= '0;
            o_warn_cnt        <= '0;
            o_err_cnt         <= '0;
            o_fatal           <= 1'b0;
            o_first_err_valid <= 1'b0;
            o_first_err_id    <= '0;
        end else if (clear) begin
            o_info_cnt        <= '0;
            o_warn_cnt        <= '0;
            o_err_cnt         <= '0;
            o_fatal           <= 1'b0;
            o_first_err_valid <= 1'b0;
            o_first_err_id    <= '0;
        end else if (accept) begin
            unique case (evt.evt_sev)
                2'd0:    o_info_cnt <= sat_inc(o_info_cnt);
                2'd1:    o_warn_cnt <= sat_inc(o_warn_cnt);
                2'd2:    o_err_cnt  <= err_nxt;
                default: o_fatal    <= 1'b1;
            endcase
            if (is_bad && !o_first_err_valid) begin
                o_first_err_valid <= 1'b1;
                o_first_err_id    <= evt.evt_id;
            end
        end
    end

    assign o_pass = (state == DONE) && (o_err_cnt == '0)
                    && !o_fatal && !o_timeout;

endmodule

// File: tb/tb_test_status_collector.sv
// Scoreboarded bench for test_status_collector: three instances cover the
// default build, a short watchdog, and 4-bit counters with no watchdog.
module tb_test_status_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: defaults
    logic        a_start, a_done;
    logic [15:0] a_info, a_warn, a_err;
    logic        a_fatal, a_fv, a_tmo, a_busy, a_fin, a_pass;
    logic [7:0]  a_fid;
    test_status_collector_if #(.ID_WIDTH(8)) a_if();

    test_status_collector dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_start(a_start), .evt(a_if),
        .i_done(a_done), .o_info_cnt(a_info), .o_warn_cnt(a_warn),
        .o_err_cnt(a_err), .o_fatal(a_fatal), .o_first_err_valid(a_fv),
        .o_first_err_id(a_fid), .o_timeout(a_tmo), .o_busy(a_busy),
        .o_finish(a_fin), .o_pass(a_pass)
    );

    // Instance B: TIMEOUT=8
    logic        b_start, b_done;
    logic [15:0] b_info, b_warn, b_err;
    logic        b_fatal, b_fv, b_tmo, b_busy, b_fin, b_pass;
    logic [7:0]  b_fid;
    test_status_collector_if #(.ID_WIDTH(8)) b_if();

    test_status_collector #(.TIMEOUT(8)) dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_start(b_start), .evt(b_if),
        .i_done(b_done), .o_info_cnt(b_info), .o_warn_cnt(b_warn),
        .o_err_cnt(b_err), .o_fatal(b_fatal), .o_first_err_valid(b_fv),
        .o_first_err_id(b_fid), .o_timeout(b_tmo), .o_busy(b_busy),
        .o_finish(b_fin), .o_pass(b_pass)
    );

    // Instance C: 4-bit counters, no watchdog, errors never trigger
    logic        c_start, c_done;
    logic [3:0]  c_info, c_warn, c_err;
    logic        c_fatal, c_fv, c_tmo, c_busy, c_fin, c_pass;
    logic [7:0]  c_fid;
    test_status_collector_if #(.ID_WIDTH(8)) c_if();

    test_status_collector #(
        .CNT_WIDTH(4), .TIMEOUT(0), .MAX_ERRORS(0)
    ) dut_c (
        .i_clk(clk), .i_rst(rst_n), .i_start(c_start), .evt(c_if),
        .i_done(c_done), .o_info_cnt(c_info), .o_warn_cnt(c_warn),
        .o_err_cnt(c_err), .o_fatal(c_fatal), .o_first_err_valid(c_fv),
        .o_first_err_id(c_fid), .o_timeout(c_tmo), .o_busy(c_busy),
        .o_finish(c_fin), .o_pass(c_pass)
    );

    typedef struct {
        int info; int warn; int err;
        bit fatal; bit fv; int fid; bit tmo; bit pass; int fin;
    } exp_t;

    exp_t sb_q[$];

    // Scoreboard for instance A: every finish pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && a_fin === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL a_unexpected_finish got=1 want=0 cyc=%0d", cyc);
            end else begin
                e = sb_q.pop_front();
                if (cyc !== e.fin) begin
                    n_bad++;
                    $display("FAIL a_finish_cycle got=%0d want=%0d", cyc, e.fin);
                end
                n_cmp++;
                if ({a_info, a_warn, a_err} !==
                    {16'(e.info), 16'(e.warn), 16'(e.err)}) begin
                    n_bad++;
                    $display("FAIL a_counts got=%0d/%0d/%0d want=%0d/%0d/%0d",
                             a_info, a_warn, a_err, e.info, e.warn, e.err);
                end
                n_cmp++;
                if ({a_fatal, a_fv, a_fid, a_tmo, a_pass} !==
                    {e.fatal, e.fv, 8'(e.fid), e.tmo, e.pass}) begin
                    n_bad++;
                    $display("FAIL a_flags got=f%0b v%0b id%0h t%0b p%0b want=f%0b v%0b id%0h t%0b p%0b",
                             a_fatal, a_fv, a_fid, a_tmo, a_pass,
                             e.fatal, e.fv, e.fid, e.tmo, e.pass);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({a_if.evt_ready, a_busy, a_fin, a_pass, a_fatal, a_fv, a_tmo}
            !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_flags got=%b want=0000000",
                     {a_if.evt_ready, a_busy, a_fin, a_pass,
                      a_fatal, a_fv, a_tmo});
        end
        n_cmp++;
        if ({a_info, a_warn, a_err, a_fid} !== 56'd0) begin
            n_bad++;
            $display("FAIL reset_counts got=%0d/%0d/%0d id=%0h want=0",
                     a_info, a_warn, a_err, a_fid);
        end
        rst_n = 1'b1;
        a_done = 1'b1;
        repeat (2) tick();
        a_done = 1'b0;
        n_cmp++;
        if ({a_busy, a_if.evt_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL done_in_idle got=%b want=00",
                     {a_busy, a_if.evt_ready});
        end
    endtask

    task automatic test_clean_run();
        int t0, td, k;
        exp_t e;
        a_start = 1'b1;
        t0 = cyc;
        tick();
        a_start = 1'b0;
        n_cmp++;
        if ({a_busy, a_if.evt_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL clean_run_entry got=%b want=11",
                     {a_busy, a_if.evt_ready});
        end
        for (int i = 0; i < 5; i++) begin
            a_if.evt_valid = 1'b1;
            a_if.evt_sev = (i < 3) ? 2'd0 : 2'd1;
            a_if.evt_id = 8'(i);
            tick();
            if (i == 0) begin
                n_cmp++;
                if (a_info !== 16'd1) begin
                    n_bad++;
                    $display("FAIL count_latency got=%0d want=1", a_info);
                end
            end
        end
        a_if.evt_valid = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        while (cyc < t0 + 10) tick();
        a_done = 1'b1;
        td = cyc;
        e = '{info: 3, warn: 2, err: 0, fatal: 0, fv: 0, fid: 0,
              tmo: 0, pass: 1, fin: td + 5};
        sb_q.push_back(e);
        tick();
        a_done = 1'b0;
        n_cmp++;
        if ({a_busy, a_info} !== {1'b1, 16'd3}) begin
            n_bad++;
            $display("FAIL clean_drain_entry got=%b/%0d want=1/3",
                     a_busy, a_info);
        end
        k = 0;
        while (a_fin !== 1'b1 && k < 20) begin tick(); k++; end
        n_cmp++;
        if (k == 20) begin
            n_bad++;
            $display("FAIL clean_finish_wait got=none want=finish");
        end
        tick();
        n_cmp++;
        if ({a_fin, a_pass, a_if.evt_ready} !== 3'b010) begin
            n_bad++;
            $display("FAIL clean_done_hold got=%b want=010",
                     {a_fin, a_pass, a_if.evt_ready});
        end
    endtask

    task automatic test_error_stop();
        int s, k;
        exp_t e;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_if.evt_valid = 1'b1;
        a_if.evt_sev = 2'd2;
        a_if.evt_id = 8'h2A;
        s = cyc;
        e = '{info: 0, warn: 0, err: 2, fatal: 0, fv: 1, fid: 8'h2A,
              tmo: 0, pass: 0, fin: s + 5};
        sb_q.push_back(e);
        tick();
        a_if.evt_id = 8'h33;
        tick();
        a_if.evt_valid = 1'b0;
        n_cmp++;
        if ({a_err, a_fid, a_busy} !== {16'd2, 8'h2A, 1'b1}) begin
            n_bad++;
            $display("FAIL err_drain got=%0d/%0h/%b want=2/2a/1",
                     a_err, a_fid, a_busy);
        end
        k = 0;
        while (a_fin !== 1'b1 && k < 20) begin tick(); k++; end
        n_cmp++;
        if (k == 20) begin
            n_bad++;
            $display("FAIL err_finish_wait got=none want=finish");
        end
        repeat (5) tick();
    endtask

    task automatic test_fatal();
        int s, k;
        exp_t e;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_if.evt_valid = 1'b1;
        a_if.evt_sev = 2'd3;
        a_if.evt_id = 8'h07;
        a_done = 1'b1;
        s = cyc;
        e = '{info: 0, warn: 0, err: 0, fatal: 1, fv: 1, fid: 8'h07,
              tmo: 0, pass: 0, fin: s + 5};
        sb_q.push_back(e);
        tick();
        a_if.evt_valid = 1'b0;
        a_done = 1'b0;
        n_cmp++;
        if ({a_busy, a_fatal, a_err} !== {2'b11, 16'd0}) begin
            n_bad++;
            $display("FAIL fatal_drain got=%b%b/%0d want=11/0",
                     a_busy, a_fatal, a_err);
        end
        k = 0;
        while (a_fin !== 1'b1 && k < 20) begin tick(); k++; end
        n_cmp++;
        if (k == 20) begin
            n_bad++;
            $display("FAIL fatal_finish_wait got=none want=finish");
        end
        repeat (3) tick();
    endtask

    task automatic test_watchdog();
        int s, k;
        b_start = 1'b1;
        s = cyc;
        tick();
        b_start = 1'b0;
        while (cyc < s + 8) tick();
        n_cmp++;
        if ({b_tmo, b_busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL wd_before got=%b want=01", {b_tmo, b_busy});
        end
        tick();
        n_cmp++;
        if ({b_tmo, b_busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL wd_fired got=%b want=11", {b_tmo, b_busy});
        end
        k = 0;
        while (b_fin !== 1'b1 && k < 20) begin tick(); k++; end
        n_cmp++;
        if (cyc !== s + 13 || b_pass !== 1'b0) begin
            n_bad++;
            $display("FAIL wd_finish got=cyc%0d/p%b want=cyc%0d/p0",
                     cyc, b_pass, s + 13);
        end
    endtask

    task automatic test_saturation_restart();
        int nw, sat, exp_w, k;
        nw = 20;
        sat = (1 << 4) - 1;
        exp_w = (nw > sat) ? sat : nw;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        c_if.evt_valid = 1'b1;
        c_if.evt_sev = 2'd1;
        c_if.evt_id = 8'h01;
        repeat (nw) tick();
        c_if.evt_sev = 2'd2;
        c_if.evt_id = 8'h55;
        tick();
        c_if.evt_id = 8'h66;
        tick();
        c_if.evt_sev = 2'd0;
        tick();
        c_if.evt_valid = 1'b0;
        n_cmp++;
        if ({c_warn, c_err, c_info, c_fid, c_busy} !==
            {4'(exp_w), 4'd2, 4'd1, 8'h55, 1'b1}) begin
            n_bad++;
            $display("FAIL sat_counts got=%0d/%0d/%0d/%0h/%b want=%0d/2/1/55/1",
                     c_warn, c_err, c_info, c_fid, c_busy, exp_w);
        end
        c_done = 1'b1;
        tick();
        c_done = 1'b0;
        k = 0;
        while (c_fin !== 1'b1 && k < 20) begin tick(); k++; end
        n_cmp++;
        if (k == 20 || c_pass !== 1'b0 || c_warn !== 4'(exp_w)) begin
            n_bad++;
            $display("FAIL sat_done got=k%0d/p%b/w%0d want=finish/p0/w%0d",
                     k, c_pass, c_warn, exp_w);
        end
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        n_cmp++;
        if ({c_info, c_warn, c_err, c_fid, c_fatal, c_fv, c_tmo,
             c_busy, c_if.evt_ready} !== {20'd0, 5'b00011}) begin
            n_bad++;
            $display("FAIL restart_clear got=%0d/%0d/%0d/%0h/%b want=0/0/0/0/00011",
                     c_info, c_warn, c_err, c_fid,
                     {c_fatal, c_fv, c_tmo, c_busy, c_if.evt_ready});
        end
    endtask

    task automatic test_no_timeout();
        bit ok;
        int k;
        ok = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (c_busy !== 1'b1 || c_tmo !== 1'b0) ok = 1'b0;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL no_timeout_run got=left_run want=stay_run");
        end
        c_done = 1'b1;
        tick();
        c_done = 1'b0;
        k = 0;
        while (c_fin !== 1'b1 && k < 20) begin tick(); k++; end
        n_cmp++;
        if (k == 20 || c_pass !== 1'b1) begin
            n_bad++;
            $display("FAIL no_timeout_finish got=k%0d/p%b want=finish/p1",
                     k, c_pass);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_if.evt_valid = 1'b1;
        a_if.evt_sev = 2'd0;
        tick();
        a_if.evt_valid = 1'b0;
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        n_cmp++;
        if ({a_busy, a_info} !== {1'b1, 16'd1}) begin
            n_bad++;
            $display("FAIL rst_mid_pre got=%b/%0d want=1/1", a_busy, a_info);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_info, a_busy, a_if.evt_ready, a_fin, a_pass} !== 20'd0) begin
            n_bad++;
            $display("FAIL rst_mid_async got=%0d/%b want=0/0000",
                     a_info, {a_busy, a_if.evt_ready, a_fin, a_pass});
        end
        seen = 1'b0;
        repeat (4) begin tick(); if (a_fin !== 1'b0) seen = 1'b1; end
        rst_n = 1'b1;
        repeat (8) begin tick(); if (a_fin !== 1'b0) seen = 1'b1; end
        n_cmp++;
        if (seen || {a_busy, a_if.evt_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_mid_after got=fin%b/%b want=fin0/00",
                     seen, {a_busy, a_if.evt_ready});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {a_start, a_done, b_start, b_done, c_start, c_done} = '0;
        a_if.evt_valid = 1'b0; a_if.evt_sev = '0; a_if.evt_id = '0;
        b_if.evt_valid = 1'b0; b_if.evt_sev = '0; b_if.evt_id = '0;
        c_if.evt_valid = 1'b0; c_if.evt_sev = '0; c_if.evt_id = '0;
        test_reset();
        test_clean_run();
        test_error_stop();
        test_fatal();
        test_watchdog();
        test_saturation_restart();
        test_no_timeout();
        test_reset_mid();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_finish got=%0d pending want=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
